// File: rtl/avalon_pio_pkg.sv
// Shared constants for the Avalon-MM PIO block.
//   ADDR_*  : word addresses of the register map (6-7 are reserved)
//   EDGE_*  : encodings of the EDGE_TYPE parameter
package avalon_pio_pkg;
   localparam logic [2:0] ADDR_DATA    = 3'd0;
   localparam logic [2:0] ADDR_DIR     = 3'd1;
   localparam logic [2:0] ADDR_IRQMASK = 3'd2;
   localparam logic [2:0] ADDR_EDGECAP = 3'd3;
   localparam logic [2:0] ADDR_OUTSET  = 3'd4;
   localparam logic [2:0] ADDR_OUTCLR  = 3'd5;

   localparam int EDGE_RISE = 0;
   localparam int EDGE_FALL = 1;
   localparam int EDGE_ANY  = 2;
endpackage

// File: rtl/avalon_pio_gen_if.sv
// Avalon-MM slave bus of the PIO block.
//   address/chipselect/write_n/writedata : master -> slave
//   readdata                             : slave -> master, registered
interface avalon_pio_gen_if;
   logic [2:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;

   modport master (output address, chipselect, write_n, writedata, input readdata);
   modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/pio_sync.sv
// Multi-flop synchronizer for asynchronous inputs.
//   clk, reset_n : clock, async active-low reset (chain clears to 0)
//   din          : asynchronous input vector, W bits
//   dout         : synchronized vector, STAGES cycles later
module pio_sync #(
   parameter int W      = 8,
   parameter int STAGES = 2
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout
);
   logic [STAGES-1:0][W-1:0] chain_q, chain_d;

   always_comb begin
      chain_d = {chain_q[STAGES-2:0], din};
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) chain_q <= '0;
      else          chain_q <= chain_d;
   end

   assign dout = chain_q[STAGES-1];
endmodule

// File: rtl/avalon_pio_gen.sv
// Avalon-MM general purpose PIO port.
//   clk, reset_n : clock, async active-low reset
//   bus          : Avalon-MM slave (address, chipselect, write_n, writedata, readdata)
//   in_port      : asynchronous inputs, synchronized before use
//   out_port     : data_out register, driven regardless of dir
//   oe           : per-bit output enable (dir register)
//   irq          : level interrupt, OR(edgecap & irqmask), registered
// Optional feature macro PIO_EDGE_IRQ_EN adds edge capture, irqmask and irq;
// without it irq is 0 and addresses 2-3 read 0 and ignore writes.
module avalon_pio_gen
   import avalon_pio_pkg::*;
#(
   parameter int          WIDTH       = 8,
   parameter int          SYNC_STAGES = 2,
   parameter logic [31:0] RESET_OUT   = 32'd0,
   parameter int          EDGE_TYPE   = EDGE_RISE
) (
   input  logic              clk,
   input  logic              reset_n,
   avalon_pio_gen_if.slave   bus,
   input  logic [WIDTH-1:0]  in_port,
   output logic [WIDTH-1:0]  out_port,
   output logic [WIDTH-1:0]  oe,
   output logic              irq
);
   logic [WIDTH-1:0] sync_in;
   logic [WIDTH-1:0] data_out_q, data_out_d;
   logic [WIDTH-1:0] dir_q, dir_d;
   logic [31:0]      readdata_q, readdata_d;
   logic [WIDTH-1:0] rd_word;
   logic [WIDTH-1:0] wdata;
   logic             wr;

   pio_sync #(.W(WIDTH), .STAGES(SYNC_STAGES)) u_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .din     (in_port),
      .dout    (sync_in)
   );

   assign wr    = bus.chipselect & ~bus.write_n;
   assign wdata = bus.writedata[WIDTH-1:0];

   // writedata bits above WIDTH-1 are intentionally dropped
   logic unused_wdata;
   assign unused_wdata = ^bus.writedata;

`ifdef PIO_EDGE_IRQ_EN
   logic [WIDTH-1:0] prev_q, prev_d;
   logic [WIDTH-1:0] edgecap_q, edgecap_d;
   logic [WIDTH-1:0] irqmask_q, irqmask_d;
   logic             irq_q, irq_d;
   logic [WIDTH-1:0] edge_hit;

   always_comb begin
      prev_d = sync_in;
      case (EDGE_TYPE)
         EDGE_FALL: edge_hit = ~sync_in & prev_q;
         EDGE_ANY:  edge_hit = sync_in ^ prev_q;
         default:   edge_hit = sync_in & ~prev_q;
      endcase
      irqmask_d = irqmask_q;
      edgecap_d = edgecap_q;
      if (wr && bus.address == ADDR_IRQMASK) irqmask_d = wdata;
      if (wr && bus.address == ADDR_EDGECAP) edgecap_d = edgecap_q & ~wdata;
      // applied after the clear so a coincident edge survives
      edgecap_d = edgecap_d | edge_hit;
      irq_d     = |(edgecap_q & irqmask_q);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         prev_q    <= '0;
         edgecap_q <= '0;
         irqmask_q <= '0;
         irq_q     <= 1'b0;
      end else begin
         prev_q    <= prev_d;
         edgecap_q <= edgecap_d;
         irqmask_q <= irqmask_d;
         irq_q     <= irq_d;
      end
   end

   assign irq = irq_q;
`else
   assign irq = 1'b0;
`endif

   always_comb begin
      data_out_d = data_out_q;
      dir_d      = dir_q;
      if (wr) begin
         case (bus.address)
            ADDR_DATA:   data_out_d = wdata;
            ADDR_DIR:    dir_d      = wdata;
            ADDR_OUTSET: data_out_d = data_out_q | wdata;
            ADDR_OUTCLR: data_out_d = data_out_q & ~wdata;
            default:     ;
         endcase
      end

      case (bus.address)
         // output bits read back the driven value, input bits the pin
         ADDR_DATA:    rd_word = (data_out_q & dir_q) | (sync_in & ~dir_q);
         ADDR_DIR:     rd_word = dir_q;
`ifdef PIO_EDGE_IRQ_EN
         ADDR_IRQMASK: rd_word = irqmask_q;
         ADDR_EDGECAP: rd_word = edgecap_q;
`endif
         default:      rd_word = '0;
      endcase
      readdata_d              = '0;
      readdata_d[WIDTH-1:0]   = rd_word;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data_out_q <= RESET_OUT[WIDTH-1:0];
         dir_q      <= '0;
         readdata_q <= '0;
      end else begin
         data_out_q <= data_out_d;
         dir_q      <= dir_d;
         readdata_q <= readdata_d;
      end
   end

   assign out_port     = data_out_q;
   assign oe           = dir_q;
   assign bus.readdata = readdata_q;
endmodule

// File: tb/tb_avalon_pio_gen.sv
module tb_avalon_pio_gen;
   import avalon_pio_pkg::*;

   localparam int          S       = 2;
   localparam int          EDGE    = 0;
   localparam logic [7:0]  RST_OUT = 8'hA5;
`ifdef PIO_EDGE_IRQ_EN
   localparam bit IRQ_EN = 1'b1;
`else
   localparam bit IRQ_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset_n;
   logic [7:0] in_port, out_port, oe;
   logic       irq;

   avalon_pio_gen_if bus ();

   avalon_pio_gen #(.WIDTH(8), .SYNC_STAGES(S), .RESET_OUT(32'(RST_OUT)), .EDGE_TYPE(EDGE)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .bus      (bus.slave),
      .in_port  (in_port),
      .out_port (out_port),
      .oe       (oe),
      .irq      (irq)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // reference model: register contents plus the input history since reset
   logic [7:0]  m_dout, m_dir, m_mask, m_cap;
   logic [31:0] e_rd;
   logic        e_irq;
   logic [7:0]  hist[$];

   // input value sampled at clock edge i after reset (0 before reset release)
   function automatic logic [7:0] h(input int i);
      return (i < 0) ? 8'h00 : hist[i];
   endfunction

   task automatic model_reset();
      m_dout = RST_OUT; m_dir = 0; m_mask = 0; m_cap = 0;
      e_rd = 0; e_irq = 0;
      hist.delete();
   endtask

   task automatic model_step(input logic [2:0] a, input logic cs, input logic wn,
                             input logic [31:0] wd, input logic [7:0] inp);
      int n;
      logic [7:0] syn, prv, hit, w;
      hist.push_back(inp);
      n   = hist.size() - 1;
      syn = h(n - S);        // synchronized value seen at this edge
      prv = h(n - S - 1);    // synchronized value one edge earlier
      case (a)
         3'd0:    e_rd = {24'h0, (m_dout & m_dir) | (syn & ~m_dir)};
         3'd1:    e_rd = {24'h0, m_dir};
         3'd2:    e_rd = IRQ_EN ? {24'h0, m_mask} : 32'h0;
         3'd3:    e_rd = IRQ_EN ? {24'h0, m_cap} : 32'h0;
         default: e_rd = 32'h0;
      endcase
      e_irq = IRQ_EN && ((m_cap & m_mask) != 0);
      case (EDGE)
         1:       hit = ~syn & prv;
         2:       hit = syn ^ prv;
         default: hit = syn & ~prv;
      endcase
      w = wd[7:0];
      if (cs && !wn) begin
         case (a)
            3'd0: m_dout = w;
            3'd1: m_dir  = w;
            3'd2: if (IRQ_EN) m_mask = w;
            3'd3: if (IRQ_EN) m_cap  = m_cap & ~w;
            3'd4: m_dout = m_dout | w;
            3'd5: m_dout = m_dout & ~w;
            default: ;
         endcase
      end
      if (IRQ_EN) m_cap = m_cap | hit;
   endtask

   // one bus cycle: drive at negedge, model at posedge, check at next negedge
   task automatic cyc(input logic [2:0] a, input logic cs, input logic wn,
                      input logic [31:0] wd, input logic [7:0] inp);
      bus.address = a; bus.chipselect = cs; bus.write_n = wn;
      bus.writedata = wd; in_port = inp;
      @(posedge clk);
      model_step(a, cs, wn, wd, inp);
      @(negedge clk);
      chk("readdata", bus.readdata, e_rd);
      chk("out_port", {24'h0, out_port}, {24'h0, m_dout});
      chk("oe", {24'h0, oe}, {24'h0, m_dir});
      chk("irq", {31'h0, irq}, {31'h0, e_irq});
   endtask

   task automatic wr(input logic [2:0] a, input logic [31:0] wd, input logic [7:0] inp);
      cyc(a, 1'b1, 1'b0, wd, inp);
   endtask

   task automatic idle(input logic [2:0] a, input logic [7:0] inp);
      cyc(a, 1'b0, 1'b1, 32'h0, inp);
   endtask

   task automatic check_reset();
      chk("rst_out_port", {24'h0, out_port}, {24'h0, RST_OUT});
      chk("rst_oe", {24'h0, oe}, 32'h0);
      chk("rst_readdata", bus.readdata, 32'h0);
      chk("rst_irq", {31'h0, irq}, 32'h0);
   endtask

   initial begin
      logic [7:0] cur;
      reset_n = 1'b0;
      bus.address = 0; bus.chipselect = 0; bus.write_n = 1; bus.writedata = 0;
      in_port = 0;
      #23;
      check_reset();
      @(negedge clk);
      reset_n = 1'b1;
      model_reset();

      // mixed direction readback
      wr(ADDR_DIR, 32'h0F, 8'hF0);
      wr(ADDR_DATA, 32'h3C, 8'hF0);
      for (int i = 0; i < 3; i++) idle(ADDR_DATA, 8'hF0);
      chk("rd_mixed", bus.readdata, 32'h000000FC);

      // set/clear helpers
      wr(ADDR_DATA, 32'h00, 8'hF0);
      wr(ADDR_OUTSET, 32'h81, 8'hF0);
      chk("outset", {24'h0, out_port}, 32'h81);
      wr(ADDR_OUTCLR, 32'h01, 8'hF0);
      chk("outclr", {24'h0, out_port}, 32'h80);

`ifdef PIO_EDGE_IRQ_EN
      // edge capture and irq
      for (int i = 0; i < S + 2; i++) idle(ADDR_DATA, 8'h00);
      wr(ADDR_IRQMASK, 32'h04, 8'h00);
      wr(ADDR_EDGECAP, 32'hFF, 8'h00);
      idle(ADDR_EDGECAP, 8'h00);
      chk("irq_idle", {31'h0, irq}, 32'h0);
      for (int i = 0; i < S + 2; i++) idle(ADDR_EDGECAP, 8'h04);
      chk("edge_irq", {31'h0, irq}, 32'h1);
      chk("edge_cap", bus.readdata, 32'h04);
      wr(ADDR_EDGECAP, 32'h04, 8'h04);
      idle(ADDR_EDGECAP, 8'h04);
      chk("irq_cleared", {31'h0, irq}, 32'h0);

      // edge arriving on the same edge as the clear write
      for (int i = 0; i < S + 2; i++) idle(ADDR_DATA, 8'h00);
      wr(ADDR_EDGECAP, 32'hFF, 8'h00);
      for (int i = 0; i < S; i++) idle(ADDR_DATA, 8'h04);
      wr(ADDR_EDGECAP, 32'h04, 8'h04);
      idle(ADDR_EDGECAP, 8'h04);
      chk("set_wins", bus.readdata, 32'h04);
`else
      wr(3'd2, 32'hFF, 8'h00);
      idle(3'd2, 8'h00);
      chk("no_irqmask", bus.readdata, 32'h0);
      idle(3'd3, 8'h00);
      chk("no_edgecap", bus.readdata, 32'h0);
`endif

      // reserved address write and reads of 4-7
      wr(3'd7, 32'hFFFFFFFF, 8'h00);
      for (int a = 4; a < 8; a++) begin
         idle(3'(a), 8'h00);
         chk("rd_hi_addr", bus.readdata, 32'h0);
      end
      chk("rsvd_out", {24'h0, out_port}, 32'h80);
      chk("rsvd_dir", {24'h0, oe}, 32'h0F);

      // random traffic, with a reset taken while inputs are held high
      cur = 8'h00;
      for (int i = 0; i < 600; i++) begin
         if (i == 300) begin
            cur = 8'hFF;
            in_port = cur;
            reset_n = 1'b0;
            #1;
            check_reset();
            @(negedge clk);
            reset_n = 1'b1;
            model_reset();
         end
         if ($urandom_range(3) == 0) cur = 8'($urandom);
         cyc(3'($urandom_range(7)), 1'($urandom), 1'($urandom), $urandom, cur);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
